id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and execute-stage operand select, directly upstream of the ALU.
- Captures decoded operands and control from decode each cycle, honouring stall and flush.
- Drives the ALU inputs src_a_e, src_b_e and alu_control_e (3-bit; 000 add, 001 sub, 010 and, 011 or, 101 slt, others default).
- Resolves data hazards by muxing forwarded values from the MEM and WB stages.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register-file index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_e  input  1  hold all stage registers.
- flush_e  input  1  load a bubble on the next edge.
- id_valid  input  1  decode slot holds a real instruction.
- id_rd1, id_rd2  input  XLEN  register-file read data.
- id_imm_ext, id_pc  input  XLEN  extended immediate, instruction PC.
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W  source/destination indices.
- id_alu_control  input  3  ALU operation.
- id_alu_src  input  1  1 selects the immediate for operand B.
- id_reg_write, id_mem_write, id_branch, id_jump  input  1  control bits.
- id_result_src  input  2  writeback source select.
- forward_a_e, forward_b_e  input  2  forwarding selects from the hazard unit.
- alu_result_m, result_w  input  XLEN  forwarded MEM and WB values.
- src_a_e, src_b_e  output  XLEN  ALU operands.
- alu_control_e  output  3  registered ALU operation.
- write_data_e  output  XLEN  forwarded rs2 value, for stores.
- pc_e, imm_ext_e  output  XLEN  registered PC and immediate.
- rs1_e, rs2_e, rd_e  output  REG_ADDR_W  registered indices, fed to the hazard unit.
- reg_write_e, mem_write_e, branch_e, jump_e, valid_e  output  1  registered control bits.
- result_src_e  output  2  registered writeback select.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - All stage registers clear to 0.
  - The outputs therefore form a NOP: alu_control_e = 000, every control bit 0, valid_e = 0.
  - Registers stay 0 while rst_n is low.
  - Deassertion is sampled on the next rising edge.
- Register update on each rising edge, in priority order:
  - flush_e = 1: load a bubble. Every register, data and control, becomes 0.
  - else stall_e = 1: hold all registers.
  - else: capture all id_* inputs. valid_e takes id_valid.
- Simultaneous flush_e and stall_e: flush wins.
- Register latency is 1 cycle from ID to E.
- Forwarding mux, combinational on the registered rd1/rd2:
  - 00 selects the registered value.
  - 10 selects alu_result_m.
  - 01 selects result_w.
  - 11 is reserved and behaves as 00.
  - A and B muxes are independent.
- Operand outputs:
  - src_a_e = forwarded A.
  - write_data_e = forwarded B.
  - src_b_e = imm_ext_e when the registered alu_src = 1, otherwise forwarded B.
- Forward selects and alu_result_m/result_w act combinationally during a stall. Operands track them with no registered delay.
- Bubble/reset operands are 0, so src_a_e = src_b_e = 0 and the ALU result is 0.
- No arithmetic is performed. Widths pass through unchanged.

Test Plan:
- Reset mid-operation: load id_rd1 = 32'd10 with reg_write = 1, then pull rst_n low between edges → all outputs 0 immediately, alu_control_e = 000.
- Normal capture: id_rd1 = 10, id_rd2 = 5, alu_control = 001, alu_src = 0, forwards 00 → one edge later src_a_e = 10, src_b_e = 5, alu_control_e = 001, valid_e = 1.
- Immediate select: id_alu_src = 1, id_imm_ext = 32'hFFFFFFFC, id_rd2 = 7 → src_b_e = FFFFFFFC, write_data_e = 7.
- Forwarding: registered rd1 = 1, rd2 = 2, alu_result_m = 32'hF0F0F0F0, result_w = 32'h0F0F0F0F:
  - forward_a_e = 10, forward_b_e = 01 → src_a_e = F0F0F0F0, src_b_e = 0F0F0F0F.
  - Both selects 11 → src_a_e = 1, src_b_e = 2.
- Stall: capture alu_control 101, then hold stall_e = 1 for 3 edges while the id_* inputs change → outputs unchanged, alu_control_e = 101.
- Flush priority: assert flush_e and stall_e together with reg_write_e = 1 held → after the edge, reg_write_e = 0, mem_write_e = 0, valid_e = 0, src_a_e = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : ID/EX pipeline register with MEM/WB forwarding operand select
// Rev 1.0
// ============================================================================
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_rd1,
  input  logic [XLEN-1:0]       id_rd2,
  input  logic [XLEN-1:0]       id_imm_ext,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_alu_control,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic [1:0]            id_result_src,
  input  logic [1:0]            forward_a_e,
  input  logic [1:0]            forward_b_e,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       result_w,
  output logic [XLEN-1:0]       src_a_e,
  output logic [XLEN-1:0]       src_b_e,
  output logic [2:0]            alu_control_e,
  output logic [XLEN-1:0]       write_data_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic                  valid_e,
  output logic [1:0]            result_src_e
);

  localparam logic [1:0] C_FWD_WB  = 2'b01;
  localparam logic [1:0] C_FWD_MEM = 2'b10;

  logic [XLEN-1:0]       r_rd1;
  logic [XLEN-1:0]       r_rd2;
  logic [XLEN-1:0]       r_imm_ext;
  logic [XLEN-1:0]       r_pc;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [2:0]            r_alu_control;
  logic                  r_alu_src;
  logic                  r_reg_write;
  logic                  r_mem_write;
  logic                  r_branch;
  logic                  r_jump;
  logic                  r_valid;
  logic [1:0]            r_result_src;

  logic [XLEN-1:0]       w_fwd_a;
  logic [XLEN-1:0]       w_fwd_b;

  // Flush outranks stall so a squashed instruction can never be held in E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm_ext     <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_alu_control <= '0;
      r_alu_src     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_jump        <= 1'b0;
      r_valid       <= 1'b0;
      r_result_src  <= '0;
    end else if (flush_e) begin
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm_ext     <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_alu_control <= '0;
      r_alu_src     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_jump        <= 1'b0;
      r_valid       <= 1'b0;
      r_result_src  <= '0;
    end else if (!stall_e) begin
      r_rd1         <= id_rd1;
      r_rd2         <= id_rd2;
      r_imm_ext     <= id_imm_ext;
      r_pc          <= id_pc;
      r_rs1         <= id_rs1;
      r_rs2         <= id_rs2;
      r_rd          <= id_rd;
      r_alu_control <= id_alu_control;
      r_alu_src     <= id_alu_src;
      r_reg_write   <= id_reg_write;
      r_mem_write   <= id_mem_write;
      r_branch      <= id_branch;
      r_jump        <= id_jump;
      r_valid       <= id_valid;
      r_result_src  <= id_result_src;
    end
  end

  // Select 11 is reserved and falls back to the registered operand.
  always_comb begin
    w_fwd_a = r_rd1;
    case (forward_a_e)
      C_FWD_MEM: w_fwd_a = alu_result_m;
      C_FWD_WB:  w_fwd_a = result_w;
      default:   w_fwd_a = r_rd1;
    endcase
  end

  always_comb begin
    w_fwd_b = r_rd2;
    case (forward_b_e)
      C_FWD_MEM: w_fwd_b = alu_result_m;
      C_FWD_WB:  w_fwd_b = result_w;
      default:   w_fwd_b = r_rd2;
    endcase
  end

  assign src_a_e       = w_fwd_a;
  assign write_data_e  = w_fwd_b;
  assign src_b_e       = r_alu_src ? r_imm_ext : w_fwd_b;
  assign alu_control_e = r_alu_control;
  assign pc_e          = r_pc;
  assign imm_ext_e     = r_imm_ext;
  assign rs1_e         = r_rs1;
  assign rs2_e         = r_rs2;
  assign rd_e          = r_rd;
  assign reg_write_e   = r_reg_write;
  assign mem_write_e   = r_mem_write;
  assign branch_e      = r_branch;
  assign jump_e        = r_jump;
  assign valid_e       = r_valid;
  assign result_src_e  = r_result_src;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : randomized self-checking bench for id_ex_stage
// Rev 1.0
// ============================================================================
module tb_id_ex_stage;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stall_e, flush_e, id_valid;
  logic [XLEN-1:0]       id_rd1, id_rd2, id_imm_ext, id_pc;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]            id_alu_control;
  logic                  id_alu_src, id_reg_write, id_mem_write, id_branch, id_jump;
  logic [1:0]            id_result_src;
  logic [1:0]            forward_a_e, forward_b_e;
  logic [XLEN-1:0]       alu_result_m, result_w;
  logic [XLEN-1:0]       src_a_e, src_b_e, write_data_e, pc_e, imm_ext_e;
  logic [2:0]            alu_control_e;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic                  reg_write_e, mem_write_e, branch_e, jump_e, valid_e;
  logic [1:0]            result_src_e;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm_ext(id_imm_ext), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_jump(id_jump), .id_result_src(id_result_src),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .alu_result_m(alu_result_m), .result_w(result_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_e(alu_control_e),
    .write_data_e(write_data_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
    .valid_e(valid_e), .result_src_e(result_src_e)
  );

  // Reference: the instruction currently sitting in E, as a plain record.
  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic        alu_src, reg_write, mem_write, branch, jump;
    logic [1:0]  rsrc;
  } stage_t;

  stage_t m;

  function automatic stage_t bubble();
    stage_t s;
    s.valid = 0; s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.pc = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.alu = 0; s.alu_src = 0;
    s.reg_write = 0; s.mem_write = 0; s.branch = 0; s.jump = 0; s.rsrc = 0;
    return s;
  endfunction

  function automatic stage_t from_id();
    stage_t s;
    s.valid = id_valid; s.rd1 = id_rd1; s.rd2 = id_rd2; s.imm = id_imm_ext;
    s.pc = id_pc; s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd;
    s.alu = id_alu_control; s.alu_src = id_alu_src; s.reg_write = id_reg_write;
    s.mem_write = id_mem_write; s.branch = id_branch; s.jump = id_jump;
    s.rsrc = id_result_src;
    return s;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own);
    if (sel == 2'b10) return alu_result_m;
    if (sel == 2'b01) return result_w;
    return own;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] fb;
    fb = pick(forward_b_e, m.rd2);
    check({tag, ".src_a"}, src_a_e, pick(forward_a_e, m.rd1));
    check({tag, ".src_b"}, src_b_e, m.alu_src ? m.imm : fb);
    check({tag, ".wdata"}, write_data_e, fb);
    check({tag, ".alu"}, 32'(alu_control_e), 32'(m.alu));
    check({tag, ".pc"}, pc_e, m.pc);
    check({tag, ".imm"}, imm_ext_e, m.imm);
    check({tag, ".regs"}, {17'd0, rs1_e, rs2_e, rd_e}, {17'd0, m.rs1, m.rs2, m.rd});
    check({tag, ".ctl"}, {25'd0, reg_write_e, mem_write_e, branch_e, jump_e, valid_e, result_src_e},
          {25'd0, m.reg_write, m.mem_write, m.branch, m.jump, m.valid, m.rsrc});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush_e) m = bubble();
    else if (!stall_e) m = from_id();
    #1;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_rd1 = $urandom; id_rd2 = $urandom;
    id_imm_ext = $urandom; id_pc = $urandom;
    id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
    id_alu_control = 3'($urandom); id_alu_src = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_write = 1'($urandom);
    id_branch = 1'($urandom); id_jump = 1'($urandom); id_result_src = 2'($urandom);
  endtask

  task automatic set_plain(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    rand_id();
    id_valid = 1; id_rd1 = a; id_rd2 = b; id_alu_control = op; id_alu_src = 0;
    stall_e = 0; flush_e = 0;
  endtask

  initial begin
    m = bubble();
    rst_n = 0; stall_e = 0; flush_e = 0;
    forward_a_e = 0; forward_b_e = 0; alu_result_m = $urandom; result_w = $urandom;
    rand_id();
    #1 check_all("reset");
    tick(); tick();
    check_all("reset_hold");
    #2 rst_n = 1;

    // Normal capture
    set_plain(32'd10, 32'd5, 3'b001);
    tick();
    check("cap.src_a", src_a_e, 32'd10);
    check("cap.src_b", src_b_e, 32'd5);
    check("cap.alu", 32'(alu_control_e), 32'd1);
    check("cap.valid", 32'(valid_e), 32'd1);
    check_all("cap");

    // Immediate select
    set_plain(32'd3, 32'd7, 3'b000);
    id_alu_src = 1; id_imm_ext = 32'hFFFFFFFC;
    tick();
    check("imm.src_b", src_b_e, 32'hFFFFFFFC);
    check("imm.wdata", write_data_e, 32'd7);

    // Forwarding
    set_plain(32'd1, 32'd2, 3'b010);
    tick();
    alu_result_m = 32'hF0F0F0F0; result_w = 32'h0F0F0F0F;
    forward_a_e = 2'b10; forward_b_e = 2'b01;
    #1;
    check("fwd.src_a", src_a_e, 32'hF0F0F0F0);
    check("fwd.src_b", src_b_e, 32'h0F0F0F0F);
    forward_a_e = 2'b11; forward_b_e = 2'b11;
    #1;
    check("fwd11.src_a", src_a_e, 32'd1);
    check("fwd11.src_b", src_b_e, 32'd2);
    forward_a_e = 2'b01; forward_b_e = 2'b10;
    #1 check_all("fwd_swap");
    forward_a_e = 0; forward_b_e = 0;

    // Stall holds for three edges while decode changes
    set_plain(32'd44, 32'd55, 3'b101);
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_id(); stall_e = 1; flush_e = 0;
      tick();
      check("stall.alu", 32'(alu_control_e), 32'd5);
      check("stall.src_a", src_a_e, 32'd44);
      check_all("stall");
    end

    // Flush beats stall
    set_plain(32'd9, 32'd8, 3'b011);
    id_reg_write = 1; id_mem_write = 1;
    tick();
    rand_id(); stall_e = 1; flush_e = 1;
    tick();
    check("flush.reg_write", 32'(reg_write_e), 32'd0);
    check("flush.mem_write", 32'(mem_write_e), 32'd0);
    check("flush.valid", 32'(valid_e), 32'd0);
    check("flush.src_a", src_a_e, 32'd0);
    check_all("flush");

    // Asynchronous reset between edges
    set_plain(32'd10, 32'd6, 3'b001);
    id_reg_write = 1;
    tick();
    #2 rst_n = 0;
    m = bubble();
    #1;
    check("arst.src_a", src_a_e, 32'd0);
    check("arst.reg_write", 32'(reg_write_e), 32'd0);
    check("arst.alu", 32'(alu_control_e), 32'd0);
    check_all("arst");
    @(negedge clk) rst_n = 1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush_e = ($urandom_range(0, 9) == 0);
      stall_e = ($urandom_range(0, 4) == 0);
      tick();
      check_all("rnd");
      forward_a_e = 2'($urandom); forward_b_e = 2'($urandom);
      alu_result_m = $urandom; result_w = $urandom;
      #1 check_all("rnd_fwd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
